// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into CHUNK-bit slices, one slice per stage, valid/ready on both sides.
// Optional signed-overflow output ov is enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ov
`endif
);
  localparam int NSTAGE = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("pipelined_adder: WIDTH must be an integer multiple of CHUNK");
  end

  logic             adv;
  logic             rv [NSTAGE];
  logic             rc [NSTAGE];
  logic [WIDTH-1:0] ra [NSTAGE];
  logic [WIDTH-1:0] rb [NSTAGE];
  logic [WIDTH-1:0] rs [NSTAGE];
  logic             pv [NSTAGE];
  logic             pc [NSTAGE];
  logic [WIDTH-1:0] pa [NSTAGE];
  logic [WIDTH-1:0] pb [NSTAGE];
  logic [WIDTH-1:0] ps [NSTAGE];
  logic [WIDTH-1:0] ns [NSTAGE];
  logic             nc [NSTAGE];

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = rv[NSTAGE-1];
  assign s         = rs[NSTAGE-1];
  assign co        = rc[NSTAGE-1];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_st
    logic [CHUNK:0] t;
    if (k == 0) begin : g_first
      assign pv[k] = in_valid;
      assign pa[k] = a;
      assign pb[k] = b ^ {WIDTH{sub}};
      assign pc[k] = ci;
      assign ps[k] = '0;
    end else begin : g_next
      assign pv[k] = rv[k-1];
      assign pa[k] = ra[k-1];
      assign pb[k] = rb[k-1];
      assign pc[k] = rc[k-1];
      assign ps[k] = rs[k-1];
    end
    assign t     = {1'b0, pa[k][k*CHUNK +: CHUNK]} + {1'b0, pb[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, pc[k]};
    assign ns[k] = ps[k] | (WIDTH'(t[CHUNK-1:0]) << (k * CHUNK));
    assign nc[k] = t[CHUNK];
  end

  // every stage shifts one position on adv and holds otherwise; a rejected input becomes a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTAGE; i++) begin
        rv[i] <= 1'b0;
        rc[i] <= 1'b0;
        ra[i] <= '0;
        rb[i] <= '0;
        rs[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < NSTAGE; i++) begin
        rv[i] <= pv[i];
        rc[i] <= nc[i];
        ra[i] <= pa[i];
        rb[i] <= pb[i];
        rs[i] <= ns[i];
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic ov_n;
  assign ov_n = (pa[NSTAGE-1][WIDTH-1] == pb[NSTAGE-1][WIDTH-1]) & (ns[NSTAGE-1][WIDTH-1] != pa[NSTAGE-1][WIDTH-1]);
  // overflow is formed alongside the MSB slice so it leaves aligned with s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ov <= 1'b0;
    else if (adv) ov <= ov_n;
  end
`endif
endmodule
